prt_access_ctrl: RTL and testbench
==================================

Name: prt_access_ctrl

Overview:
- Request/response front-end that owns port A of the PRT bit-table BRAM (1-bit data, 16-bit address, 2-cycle read latency).
- Sits between the packet classification stage and the PRT.
- Turns single-word ops (READ, SET, CLEAR, TEST_AND_SET) into correctly timed BRAM port-A cycles, hiding read latency and read-modify-write sequencing behind a valid/ready handshake.

Parameters:
- ADDR_W, 16, PRT address width; table depth is 2**ADDR_W.
- READ_LAT, 2, BRAM read latency in clka edges; legal values are 1 to 4.

Ports:
- clka  in  1  clock, shared with PRT port A.
- rsta  in  1  reset, synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  op: 0 READ, 1 SET, 2 CLEAR, 3 TEST_AND_SET.
- req_addr  in  ADDR_W  table address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  1  READ: stored bit; SET/CLEAR: written bit; TEST_AND_SET: pre-op bit.
- init_done  out  1  table ready for traffic.
- bram_we  out  1  to PRT wea.
- bram_addr  out  ADDR_W  to PRT addra.
- bram_din  out  1  to PRT dina.
- bram_dout  in  1  from PRT douta.

Behaviour:
- Interface: one clock (clka); reset rsta is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, bram_we=0, bram_addr=0, bram_din=0, init_done=0.
- All BRAM-side outputs are registered.
- One op is outstanding at a time. Same-address hazards on port A therefore cannot occur.
- req_ready=1 only in IDLE with init_done=1. A request is accepted on the edge where req_valid and req_ready are both 1. req_op and req_addr are latched on that edge.
- FSM states: INIT, IDLE, ISSUE, WAIT, CAPTURE, WRITE, RESP.
- Cycle numbering: accept edge = E0. ISSUE drives bram_addr during E0..E1; the BRAM samples it at E1.
- READ: IDLE→ISSUE(we=0)→WAIT. WAIT counts READ_LAT-1 edges, then CAPTURE registers bram_dout at edge E1+READ_LAT+1 into rsp_data. Then RESP. rsp_valid rises at E(READ_LAT+2), i.e. E4 at default.
- SET/CLEAR: ISSUE drives we=1 and din=1/0 for exactly one cycle. Then RESP with rsp_valid rising at E2 and rsp_data equal to the written bit.
- TEST_AND_SET: read path as READ up to CAPTURE.
  - If the captured bit is 0: WRITE drives we=1, din=1 for one cycle at the same address, and rsp_valid rises at E(READ_LAT+3).
  - If the captured bit is 1: no write; RESP is entered directly.
  - In both cases rsp_data = captured bit (1 = duplicate).
- RESP: rsp_valid and rsp_data are held stable until rsp_ready=1. On that edge rsp_valid=0 and the FSM returns to IDLE; req_ready rises in the following cycle. There is no back-to-back accept in the same edge.
- bram_we is never 1 outside ISSUE (SET/CLEAR), WRITE and INIT.
- Reset mid-op: the op is aborted at the rsta edge with no response. bram_we is 0 from that edge. A TEST_AND_SET reset before WRITE leaves the table unmodified.
- rsta held high: all outputs stay at their reset values.
- Port B belongs to the downstream consumer. A same-address, same-cycle write from both ports is a system-level rule violation and is not arbitrated here.

Optional Feature:
- Macro: PRT_INIT_CLEAR_EN.
- Defined:
  - After reset the FSM enters INIT and writes 0 to addresses 0..2**ADDR_W-1, one per cycle with bram_we=1.
  - A sweep counter wraps to 0 at the end of the sweep.
  - init_done rises the cycle after the last write (2**ADDR_W+1 cycles after reset release).
  - Requests are blocked during the sweep. Reset during INIT restarts the sweep from 0.
- Undefined: no INIT state; init_done=1 from the first cycle after reset release.

Decomposition:
- Package prt_pkg holds:
  - the prt_op_e enum (READ, SET, CLEAR, TEST_AND_SET);
  - PRT_ADDR_W=16 and PRT_READ_LAT=2 constants;
  - the FSM state enum.
- No sub-module: the FSM, latency counter and sweep counter fit in one module.

Test Plan:
- Write/readback: SET 0x0001, then READ 0x0001 → SET rsp_data=1 at E2; READ rsp_data=1 at E4; bram_we high exactly one cycle.
- Test-and-set duplicate: TAS 0x00FF twice → first rsp_data=0 with one write pulse; second rsp_data=1 with no bram_we pulse.
- Backpressure: READ 0x0100 with rsp_ready=0 for 10 cycles → rsp_valid/rsp_data stable, req_ready=0 throughout, IDLE one cycle after the handshake.
- Boundaries: SET 0x0000, SET 0xFFFF, CLEAR 0xFFFF, then READ both → 1 and 0; no address aliasing.
- Reset mid-TAS: TAS 0x0A00 on a 0-cell, rsta asserted in WAIT → no response, no write; a later READ 0x0A00 → 0.
- PRT_INIT_CLEAR_EN, ADDR_W=4: preloaded memory, reset → 16 consecutive we pulses on addresses 0..15; init_done rises at cycle 17; READ of any address → 0.

Source files
------------

// File: rtl/prt_pkg.sv
// -----------------------------------------------------------------------------
// prt_pkg
// Shared types and constants for the PRT bit-table access controller.
//   prt_op_e     : request opcodes carried on req_op
//   prt_state_e  : controller FSM states
//   PRT_ADDR_W   : default table address width
//   PRT_READ_LAT : default BRAM read latency (clka edges)
// -----------------------------------------------------------------------------
package prt_pkg;

   localparam int PRT_ADDR_W   = 16;
   localparam int PRT_READ_LAT = 2;

   typedef enum logic [1:0] {
      OP_READ         = 2'd0,
      OP_SET          = 2'd1,
      OP_CLEAR        = 2'd2,
      OP_TEST_AND_SET = 2'd3
   } prt_op_e;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_WRITE   = 3'd5,
      ST_RESP    = 3'd6
   } prt_state_e;

endpackage

// File: rtl/prt_access_ctrl.sv
// -----------------------------------------------------------------------------
// prt_access_ctrl
// Request/response front-end owning port A of the PRT bit-table BRAM.
// Converts single-word ops (READ, SET, CLEAR, TEST_AND_SET) into BRAM port-A
// cycles behind a valid/ready handshake, one op outstanding at a time.
//
// Parameters
//   ADDR_W    table address width (depth 2**ADDR_W)
//   READ_LAT  BRAM read latency in clka edges, 1..4
//
// Ports
//   clka, rsta            clock and synchronous active-high reset
//   req_valid/req_ready   request handshake; req_op, req_addr latched on accept
//   rsp_valid/rsp_ready   response handshake; rsp_data held until accepted
//   init_done             table ready for traffic
//   bram_we/addr/din      registered drive of PRT port A
//   bram_dout             PRT port A read data
//
// Build option
//   PRT_INIT_CLEAR_EN     when defined, every reset is followed by a sweep that
//                         writes 0 to the whole table before init_done rises.
// -----------------------------------------------------------------------------
module prt_access_ctrl
   import prt_pkg::*;
#(
   parameter int ADDR_W   = PRT_ADDR_W,
   parameter int READ_LAT = PRT_READ_LAT
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_data,
   output logic              init_done,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_din,
   input  logic              bram_dout
);

   localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

`ifdef PRT_INIT_CLEAR_EN
   localparam prt_state_e RESET_STATE = ST_INIT;
`else
   localparam prt_state_e RESET_STATE = ST_IDLE;
`endif

   prt_state_e        state_q, state_d;
   prt_op_e           op_q, op_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic              bram_we_q, bram_we_d;
   logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
   logic              bram_din_q, bram_din_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_data_q, rsp_data_d;
   logic              init_done_q, init_done_d;
   logic              op_is_write;
   logic              accept;

`ifdef PRT_INIT_CLEAR_EN
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic              sweep_done_q, sweep_done_d;
`endif

   assign req_ready   = (state_q == ST_IDLE) && init_done_q;
   assign accept      = req_valid && req_ready;
   assign op_is_write = (op_q == OP_SET) || (op_q == OP_CLEAR);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lat_cnt_d   = lat_cnt_q;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
`ifdef PRT_INIT_CLEAR_EN
      init_done_d  = init_done_q;
      sweep_d      = sweep_q;
      sweep_done_d = sweep_done_q;
`else
      init_done_d = 1'b1;
`endif

      case (state_q)
`ifdef PRT_INIT_CLEAR_EN
         ST_INIT: begin
            if (!sweep_done_q) begin
               bram_we_d   = 1'b1;
               bram_addr_d = sweep_q;
               bram_din_d  = 1'b0;
               sweep_d     = sweep_q + 1'b1;   // wraps to 0 after the last address
               if (sweep_q == {ADDR_W{1'b1}}) begin
                  sweep_done_d = 1'b1;
               end
            end else begin
               // One quiet cycle after the final write before opening for traffic.
               init_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
`endif
         ST_IDLE: begin
            if (accept) begin
               op_d        = prt_op_e'(req_op);
               bram_addr_d = req_addr;
               state_d     = ST_ISSUE;
               if ((req_op == OP_SET) || (req_op == OP_CLEAR)) begin
                  bram_we_d  = 1'b1;
                  bram_din_d = (req_op == OP_SET);
               end
            end
         end
         ST_ISSUE: begin
            // Writes take a single settle cycle; reads wait out the BRAM latency.
            lat_cnt_d = op_is_write ? 2'd0 : LAT_LOAD;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_cnt_q != 2'd0) begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end else if (op_is_write) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = (op_q == OP_SET);
               state_d     = ST_RESP;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // Address is still held, so bram_dout is stable here for any latency.
            rsp_data_d = bram_dout;
            if ((op_q == OP_TEST_AND_SET) && !bram_dout) begin
               bram_we_d  = 1'b1;
               bram_din_d = 1'b1;
               state_d    = ST_WRITE;
            end else begin
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_WRITE: begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q     <= RESET_STATE;
         op_q        <= OP_READ;
         lat_cnt_q   <= 2'd0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         init_done_q <= 1'b0;
`ifdef PRT_INIT_CLEAR_EN
         sweep_q      <= '0;
         sweep_done_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lat_cnt_q   <= lat_cnt_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         init_done_q <= init_done_d;
`ifdef PRT_INIT_CLEAR_EN
         sweep_q      <= sweep_d;
         sweep_done_q <= sweep_done_d;
`endif
      end
   end

   assign bram_we   = bram_we_q;
   assign bram_addr = bram_addr_q;
   assign bram_din  = bram_din_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_prt_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prt_access_ctrl
// Directed bench for prt_access_ctrl with a behavioural PRT port-A model.
// Default build exercises the 16-bit table; with PRT_INIT_CLEAR_EN defined it
// shrinks the table to 4 address bits, preloads ones and checks the sweep.
// -----------------------------------------------------------------------------
module tb_prt_access_ctrl;

`ifdef PRT_INIT_CLEAR_EN
   localparam int  AW      = 4;
   localparam logic PRELOAD = 1'b1;
`else
   localparam int  AW      = 16;
   localparam logic PRELOAD = 1'b0;
`endif
   localparam int RL    = 2;
   localparam int DEPTH = 1 << AW;

   logic          clka = 1'b0;
   logic          rsta = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'd0;
   logic [AW-1:0] req_addr = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic          rsp_data;
   logic          init_done;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic          bram_din;
   logic          bram_dout;

   int n_cmp = 0;
   int n_err = 0;

   // Port-A model: read-first, RL-stage read pipeline.
   logic          mem [0:DEPTH-1];
   logic [RL-1:0] rd_pipe = '0;
   logic          mem_loaded = 1'b0;
   int            we_cnt = 0;
   logic [AW-1:0] last_we_addr = '0;
   logic          last_we_din = 1'b0;

   always #5 clka = ~clka;

   prt_access_ctrl #(.ADDR_W(AW), .READ_LAT(RL)) dut (
      .clka      (clka),
      .rsta      (rsta),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .init_done (init_done),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_dout (bram_dout)
   );

   always @(posedge clka) begin
      if (!mem_loaded) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= PRELOAD;
         mem_loaded <= 1'b1;
      end else if (bram_we) begin
         mem[bram_addr] <= bram_din;
      end
      rd_pipe <= {rd_pipe[RL-2:0], mem[bram_addr]};
   end
   assign bram_dout = rd_pipe[RL-1];

   always @(negedge clka) begin
      if (bram_we) begin
         we_cnt       <= we_cnt + 1;
         last_we_addr <= bram_addr;
         last_we_din  <= bram_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transaction. Starts and ends on a negedge. hold = cycles of
   // rsp_ready=0 after rsp_valid rises, checked for stability.
   task automatic do_op(input logic [1:0] op, input logic [AW-1:0] addr, input int hold,
                        output logic data, output int lat);
      int n;
      int bad;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clka);
         n++;
      end
      chk("req_ready_before", req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      @(posedge clka);            // E0
      #1;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_addr  = '0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clka);
         lat++;
         @(negedge clka);
         if (rsp_valid) break;
      end
      chk("rsp_valid_seen", rsp_valid, 1);
      data = rsp_data;
      bad  = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clka);
         if (!rsp_valid || rsp_data !== data || req_ready) bad++;
      end
      if (hold > 0) chk("hold_stable", bad, 0);
      rsp_ready = 1'b1;
      @(posedge clka);
      #1;
      rsp_ready = 1'b0;
      @(negedge clka);
      chk("rsp_valid_drop", rsp_valid, 0);
      chk("req_ready_after", req_ready, 1);
      $display("op=%0d addr=%h data=%0d lat=%0d", op, addr, data, lat);
   endtask

   task automatic op_check(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic exp_data, input int exp_lat, input int exp_we);
      logic d;
      int   l;
      int   we0;
      we0 = we_cnt;
      do_op(op, addr, 0, d, l);
      chk({tag, "_data"}, d, exp_data);
      chk({tag, "_lat"}, l, exp_lat);
      chk({tag, "_we"}, we_cnt - we0, exp_we);
   endtask

   initial begin
      logic d;
      int   l;
      int   k;
      int   wi;
      int   bad;
      int   we0;
      int   seen;

      repeat (3) @(posedge clka);
      @(negedge clka);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_bram_din", bram_din, 0);
      chk("rst_init_done", init_done, 0);
      rsta = 1'b0;

`ifdef PRT_INIT_CLEAR_EN
      k = 0; wi = 0; bad = 0;
      while (k < 40) begin
         @(posedge clka);
         k++;
         @(negedge clka);
         if (bram_we) begin
            if (bram_addr !== wi[AW-1:0] || bram_din !== 1'b0) bad++;
            wi++;
         end
         if (init_done) break;
      end
      chk("init_addr_seq", bad, 0);
      chk("init_we_count", wi, 16);
      chk("init_done_cycle", k, 17);
      $display("init sweep: %0d writes, init_done after %0d cycles", wi, k);
      op_check("init_rd5", 2'd0, 4'h5, 1'b0, 4, 0);
      op_check("init_rd15", 2'd0, 4'hF, 1'b0, 4, 0);
      op_check("init_set3", 2'd1, 4'h3, 1'b1, 2, 1);
      op_check("init_rd3", 2'd0, 4'h3, 1'b1, 4, 0);
      op_check("init_tas7", 2'd3, 4'h7, 1'b0, 5, 1);
      op_check("init_tas7b", 2'd3, 4'h7, 1'b1, 4, 0);
`else
      @(negedge clka);
      chk("init_done_first", init_done, 1);
      chk("req_ready_first", req_ready, 1);

      // Write / readback
      op_check("set_0001", 2'd1, 16'h0001, 1'b1, 2, 1);
      chk("set_0001_addr", last_we_addr, 16'h0001);
      op_check("read_0001", 2'd0, 16'h0001, 1'b1, 4, 0);

      // Test-and-set duplicate detection
      op_check("tas_00ff_a", 2'd3, 16'h00FF, 1'b0, 5, 1);
      chk("tas_00ff_waddr", last_we_addr, 16'h00FF);
      chk("tas_00ff_wdin", last_we_din, 1);
      op_check("tas_00ff_b", 2'd3, 16'h00FF, 1'b1, 4, 0);

      // Backpressure
      op_check("set_0100", 2'd1, 16'h0100, 1'b1, 2, 1);
      do_op(2'd0, 16'h0100, 10, d, l);
      chk("bp_data", d, 1);
      chk("bp_lat", l, 4);

      // Boundaries
      op_check("set_0000", 2'd1, 16'h0000, 1'b1, 2, 1);
      op_check("set_ffff", 2'd1, 16'hFFFF, 1'b1, 2, 1);
      op_check("clr_ffff", 2'd2, 16'hFFFF, 1'b0, 2, 1);
      chk("clr_ffff_addr", last_we_addr, 16'hFFFF);
      chk("clr_ffff_din", last_we_din, 0);
      op_check("read_0000", 2'd0, 16'h0000, 1'b1, 4, 0);
      op_check("read_ffff", 2'd0, 16'hFFFF, 1'b0, 4, 0);

      // Reset in the middle of a test-and-set
      we0  = we_cnt;
      seen = 0;
      req_valid = 1'b1;
      req_op    = 2'd3;
      req_addr  = 16'h0A00;
      @(posedge clka);            // E0
      #1;
      req_valid = 1'b0;
      @(posedge clka);            // E1: now waiting on read data
      #1;
      rsta = 1'b1;
      repeat (2) begin
         @(negedge clka);
         if (rsp_valid || bram_we) seen++;
         @(posedge clka);
      end
      #1;
      rsta = 1'b0;
      repeat (6) begin
         @(negedge clka);
         if (rsp_valid) seen++;
      end
      chk("rst_tas_no_rsp", seen, 0);
      chk("rst_tas_no_we", we_cnt - we0, 0);
      op_check("read_0a00", 2'd0, 16'h0A00, 1'b0, 4, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
